// File: rtl/data_sram_bridge.sv
// Bridges the memory stage's single-cycle data access onto a handshaked
// SRAM-like bus. The pipeline is stalled until the access finishes.
module data_sram_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              dce,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [3:0]        we,
  input  logic [3:0]        dre,
  input  logic [DATA_W-1:0] din,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              data_data_ok,
  output logic              stall_req,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_rvalid
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DISCARD} state_t;

  state_t      state, nxt;
  logic        start, capture;
  logic [3:0]  lanes;
  logic [2:0]  cnt;
  logic [1:0]  size_enc;

  assign start = dce & ((|we) | (|dre)) & ~flush;
  assign lanes = we | dre;
  assign cnt   = 3'(lanes[0]) + 3'(lanes[1]) + 3'(lanes[2]) + 3'(lanes[3]);

  always_comb begin
    case (cnt)
      3'd1:    size_enc = 2'd0;
      3'd2:    size_enc = 2'd1;
      default: size_enc = 2'd2;
    endcase
  end

  always_comb begin
    nxt       = state;
    data_req  = 1'b0;
    stall_req = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        stall_req = start;
        if (start) nxt = REQ;
      end
      REQ: begin
        data_req  = 1'b1;
        stall_req = 1'b1;
        // A flush with both handshakes in one cycle has nothing left to drain.
        if (flush) begin
          if (data_addr_ok && !data_data_ok) nxt = DISCARD;
          else                               nxt = IDLE;
        end else if (data_addr_ok) begin
          nxt     = data_data_ok ? DONE : WAIT;
          capture = data_data_ok & ~data_wr;
        end
      end
      WAIT: begin
        stall_req = 1'b1;
        if (flush) begin
          nxt = data_data_ok ? IDLE : DISCARD;
        end else if (data_data_ok) begin
          nxt     = DONE;
          capture = ~data_wr;
        end
      end
      DONE:    nxt = IDLE;
      DISCARD: begin
        stall_req = 1'b1;
        if (data_data_ok) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state      <= IDLE;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= '0;
      data_wdata <= '0;
      dm_rdata   <= '0;
      dm_rvalid  <= 1'b0;
    end else begin
      state     <= nxt;
      dm_rvalid <= capture;
      if (capture) dm_rdata <= data_rdata;
      if (state == IDLE && start) begin
        data_addr  <= daddr;
        data_wr    <= |we;
        data_wdata <= din;
        data_size  <= size_enc;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed and randomized transactions against a transaction-level model of
// stall length, request length, and read-data delivery.
module tb_data_sram_bridge;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst_n;
  logic        dce, flush, data_addr_ok, data_data_ok;
  logic [31:0] daddr, din, data_rdata;
  logic [3:0]  we, dre;
  logic        data_req, data_wr, stall_req, dm_rvalid;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, dm_rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rdata = '0;

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  data_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst_n(cpu_rst_n),
    .dce(dce), .daddr(daddr), .we(we), .dre(dre), .din(din), .flush(flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_rdata(data_rdata),
    .data_data_ok(data_data_ok), .stall_req(stall_req),
    .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    dce = 0; we = 0; dre = 0; flush = 0;
    data_addr_ok = 0; data_data_ok = 0;
  endtask

  // al: REQ cycles before addr_ok; dl: cycles from accept to data_ok;
  // fl: cycle index of a one-cycle flush (0 = none, cycle 0 = start cycle).
  task automatic run_txn(input logic [3:0] w, input logic [3:0] r,
                         input logic [31:0] a, input logic [31:0] d,
                         input int al, input int dl, input int fl);
    int t_a, t_d, last, exp_stall, exp_req, exp_size;
    int sc, rc, vc, vk, bad, reqcnt, acc_k;
    bit early, normal, rd, acc, aok, dok;
    logic [31:0] new_rdata;
    t_a = al + 1;
    t_d = t_a + dl;
    rd = (w == 0);
    early = (fl >= 1) && (fl < t_a);
    normal = (fl == 0) || (fl > t_d);
    exp_stall = early ? fl + 1 : t_d + 1;
    exp_req = early ? fl : al + 1;
    case ($countones(w | r))
      1: exp_size = 0;
      2: exp_size = 1;
      default: exp_size = 2;
    endcase
    last = early ? fl : t_d;
    sc = 0; rc = 0; vc = 0; vk = -1; bad = 0; reqcnt = 0; acc = 0; acc_k = 0;
    new_rdata = exp_rdata;
    for (int k = 0; k <= last + 2; k++) begin
      @(negedge cpu_clk_50M);
      dce = (k == 0);
      we = (k == 0) ? w : 4'h0;
      dre = (k == 0) ? r : 4'h0;
      daddr = a;
      din = d;
      flush = (fl != 0) && (k == fl);
      aok = data_req && !acc && (reqcnt == al);
      dok = (aok && dl == 0) || (acc && k == acc_k + dl);
      data_addr_ok = aok;
      data_data_ok = dok;
      data_rdata = $urandom;
      if (dok && normal && rd) new_rdata = data_rdata;
      #1;
      if (stall_req) sc++;
      if (data_req) begin
        rc++;
        reqcnt++;
        if (data_addr !== a || data_wr !== (w != 0) || data_size !== 2'(exp_size) ||
            data_wdata !== d) bad++;
      end
      if (dm_rvalid) begin vc++; vk = k; end
      if (aok) begin acc = 1; acc_k = k; end
    end
    idle_inputs();
    exp_rdata = new_rdata;
    chk("stall_cycles", sc, exp_stall);
    chk("req_cycles", rc, exp_req);
    chk("req_fields", bad, 0);
    chk("rvalid_pulses", vc, (normal && rd) ? 1 : 0);
    if (normal && rd) chk("rvalid_cycle", vk, t_d + 1);
    chk("dm_rdata", dm_rdata, exp_rdata);
    chk("stall_end", stall_req, 1'b0);
  endtask

  initial begin
    logic [3:0] w, r;
    int al, dl, fl;
    idle_inputs();
    daddr = 0; din = 0; data_rdata = 0;
    cpu_rst_n = 0;
    repeat (2) @(negedge cpu_clk_50M);
    #1;
    chk("rst_req", data_req, 1'b0);
    chk("rst_stall", stall_req, 1'b0);
    chk("rst_addr", data_addr, 32'h0);
    chk("rst_rvalid", dm_rvalid, 1'b0);
    chk("rst_rdata", dm_rdata, 32'h0);
    @(negedge cpu_clk_50M);
    cpu_rst_n = 1;

    run_txn(4'b0000, 4'b1111, 32'h8000_0010, 32'h0, 0, 0, 0);  // word read
    run_txn(4'b0010, 4'b0000, 32'h8000_0022, 32'hABAB_ABAB, 3, 2, 0);  // byte store
    run_txn(4'b0000, 4'b1100, 32'h8000_0004, 32'h0, 1, 1, 0);  // half read
    run_txn(4'b0000, 4'b1111, 32'h8000_0030, 32'h0, 2, 0, 1);  // flush in REQ
    run_txn(4'b0000, 4'b1111, 32'h8000_0040, 32'h0, 0, 3, 2);  // flush in WAIT
    run_txn(4'b0000, 4'b0011, 32'h8000_0050, 32'h0, 0, 0, 1);  // flush at accept+data
    run_txn(4'b0000, 4'b1111, 32'h8000_0060, 32'h0, 1, 2, 0);  // fresh read value

    // Reset in WAIT, then a stray data_ok in IDLE.
    @(negedge cpu_clk_50M);
    dce = 1; dre = 4'hF; daddr = 32'h8000_0070;
    @(negedge cpu_clk_50M);
    dce = 0; dre = 0; data_addr_ok = 1;
    @(negedge cpu_clk_50M);
    data_addr_ok = 0; cpu_rst_n = 0;
    @(negedge cpu_clk_50M);
    cpu_rst_n = 1; data_data_ok = 1; data_rdata = 32'h5A5A_5A5A;
    #1;
    chk("wrst_req", data_req, 1'b0);
    chk("wrst_stall", stall_req, 1'b0);
    chk("wrst_wr", data_wr, 1'b0);
    chk("wrst_size", data_size, 2'd0);
    chk("wrst_addr", data_addr, 32'h0);
    chk("wrst_wdata", data_wdata, 32'h0);
    chk("wrst_rdata", dm_rdata, 32'h0);
    @(negedge cpu_clk_50M);
    data_data_ok = 0;
    #1;
    chk("stray_rvalid", dm_rvalid, 1'b0);
    chk("stray_rdata", dm_rdata, 32'h0);
    chk("stray_stall", stall_req, 1'b0);
    exp_rdata = '0;

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(1) == 1) begin
        w = 4'($urandom_range(15, 1)); r = 4'h0;
      end else begin
        w = 4'h0; r = 4'($urandom_range(15, 1));
      end
      al = $urandom_range(3);
      dl = $urandom_range(3);
      fl = ($urandom_range(1) == 1) ? 0 : $urandom_range(al + dl + 2, 1);
      run_txn(w, r, $urandom, $urandom, al, dl, fl);
      repeat ($urandom_range(2)) @(negedge cpu_clk_50M);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
